// File: rtl/nor_test_sequencer_pkg.sv
// Shared types for the NOR self-test sequencer: FSM states and LFSR constants.
// The LFSR helpers are used only when NOR_SEQ_LFSR_EN is defined.
package nor_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    SETTLE,
    CHECK,
    DONE
  } state_t;

  localparam int unsigned LFSR_W    = 16;
  // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11 + 1
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {1'b0, s[LFSR_W-1:1]} ^ (s[0] ? LFSR_TAPS : '0);
  endfunction

endpackage

// File: rtl/nor_test_sequencer_if.sv
// Operand/result bus between the sequencer (master) and the NOR datapath (slave).
interface nor_test_sequencer_if #(
  parameter int unsigned WIDTH = 1
);
  logic [WIDTH-1:0] a_o;
  logic [WIDTH-1:0] b_o;
  logic [WIDTH-1:0] y_i;

  modport master (output a_o, output b_o, input y_i);
  modport slave  (input a_o, input b_o, output y_i);
endinterface

// File: rtl/nor_test_sequencer_lfsr.sv
// 16-bit Galois LFSR with seed load and single step; o_next is the value after one step.
// Instantiated by nor_test_sequencer only when NOR_SEQ_LFSR_EN is defined.
module nor_seq_lfsr
  import nor_seq_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic              i_step,
  output logic [LFSR_W-1:0] o_next
);

  logic [LFSR_W-1:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= SEED;
    end else if (i_load) begin
      r_q <= SEED;
    end else if (i_step) begin
      r_q <= lfsr_next(r_q);
    end
  end

  assign o_next = lfsr_next(r_q);

endmodule

// File: rtl/nor_test_sequencer.sv
// Sequenced self-test of a WIDTH-bit NOR datapath: drive, settle, check, count, capture first failure.
// Define NOR_SEQ_LFSR_EN for LFSR-generated vectors; default is an exhaustive {a,b} sweep.
module nor_test_sequencer
  import nor_seq_pkg::*;
#(
  parameter int unsigned WIDTH       = 1,
  parameter int unsigned SETTLE_CYC  = 1,
  parameter int unsigned ERR_W       = 8,
  parameter int unsigned NUM_VECTORS = 64,
  parameter logic [15:0] SEED        = 16'hACE1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_i,
  input  logic                   abort_i,
  nor_test_sequencer_if.master   bus,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   pass_o,
  output logic [ERR_W-1:0]       err_cnt_o,
  output logic                   fail_valid_o,
  output logic [WIDTH-1:0]       fail_a_o,
  output logic [WIDTH-1:0]       fail_b_o,
  output logic [WIDTH-1:0]       fail_y_o
);

  localparam int unsigned VW    = 2 * WIDTH;
  localparam int unsigned SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SET_W-1:0] SET_LOAD = SET_W'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);

  state_t r_state, w_state_nxt;

  logic [WIDTH-1:0] r_a, r_b;
  logic [SET_W-1:0] r_settle;
  logic [ERR_W-1:0] r_err;
  logic             r_fail_valid, r_pass;
  logic [WIDTH-1:0] r_fail_a, r_fail_b, r_fail_y;

  logic             w_start, w_check, w_mismatch, w_last;
  logic [VW-1:0]    w_first_vec, w_next_vec;

  assign w_start    = (r_state == IDLE) && start_i && !abort_i;
  assign w_check    = (r_state == CHECK) && !abort_i;
  assign w_mismatch = (bus.y_i != ~(r_a | r_b));

`ifdef NOR_SEQ_LFSR_EN
  localparam int unsigned CNT_W = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1;

  logic [CNT_W-1:0]  r_vidx;
  logic [LFSR_W-1:0] w_lfsr_next;

  nor_seq_lfsr #(
    .SEED (SEED)
  ) u_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_start),
    .i_step (w_check && !w_last),
    .o_next (w_lfsr_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vidx <= '0;
    end else if (w_start) begin
      r_vidx <= '0;
    end else if (w_check && !w_last) begin
      r_vidx <= r_vidx + 1'b1;
    end
  end

  assign w_last      = (r_vidx == CNT_W'(NUM_VECTORS - 1));
  assign w_first_vec = SEED[VW-1:0];
  assign w_next_vec  = w_lfsr_next[VW-1:0];
`else
  // The operand registers themselves are the sweep counter; all-ones is the last vector.
  assign w_last      = &{r_a, r_b};
  assign w_first_vec = '0;
  assign w_next_vec  = {r_a, r_b} + 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_start) w_state_nxt = DRIVE;
      DRIVE:   w_state_nxt = (SETTLE_CYC == 0) ? CHECK : SETTLE;
      SETTLE:  if (r_settle == '0) w_state_nxt = CHECK;
      CHECK:   w_state_nxt = w_last ? DONE : DRIVE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    if (abort_i) w_state_nxt = IDLE;
  end

  always_comb begin
    busy_o = (r_state != IDLE);
    done_o = (r_state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a          <= '0;
      r_b          <= '0;
      r_settle     <= '0;
      r_err        <= '0;
      r_fail_valid <= 1'b0;
      r_fail_a     <= '0;
      r_fail_b     <= '0;
      r_fail_y     <= '0;
      r_pass       <= 1'b0;
    end else begin
      if (w_start) begin
        {r_a, r_b}   <= w_first_vec;
        r_err        <= '0;
        r_fail_valid <= 1'b0;
        r_fail_a     <= '0;
        r_fail_b     <= '0;
        r_fail_y     <= '0;
        r_pass       <= 1'b0;
      end
      if (r_state == DRIVE) r_settle <= SET_LOAD;
      if (r_state == SETTLE) r_settle <= r_settle - 1'b1;
      if (w_check) begin
        if (w_mismatch) begin
          if (r_err != '1) r_err <= r_err + 1'b1;
          if (!r_fail_valid) begin
            r_fail_valid <= 1'b1;
            r_fail_a     <= r_a;
            r_fail_b     <= r_b;
            r_fail_y     <= bus.y_i;
          end
        end
        if (!w_last) {r_a, r_b} <= w_next_vec;
      end
      if (r_state == DONE) r_pass <= !r_fail_valid;
      if (abort_i && (r_state != IDLE)) r_pass <= 1'b0;
    end
  end

  assign bus.a_o      = r_a;
  assign bus.b_o      = r_b;
  assign err_cnt_o    = r_err;
  assign fail_valid_o = r_fail_valid;
  assign fail_a_o     = r_fail_a;
  assign fail_b_o     = r_fail_b;
  assign fail_y_o     = r_fail_y;
  assign pass_o       = r_pass;

endmodule

// File: tb/tb_nor_test_sequencer.sv
// Randomized self-checking bench for nor_test_sequencer (WIDTH=1, SETTLE_CYC=1, ERR_W=2, exhaustive build).
// The bench plays a faultable NOR datapath and predicts each run from the sweep rules.
module tb_nor_test_sequencer;

  localparam int unsigned CYC_PER_VEC = 3;
  localparam int unsigned NVEC        = 4;
  localparam int unsigned DONE_CYC    = NVEC * CYC_PER_VEC + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_i = 1'b0;
  logic       abort_i = 1'b0;
  logic       busy_o, done_o, pass_o, fail_valid_o;
  logic [1:0] err_cnt_o;
  logic       fail_a_o, fail_b_o, fail_y_o;

  int n_cmp = 0;
  int n_bad = 0;

  // Datapath fault modes: 0 good, 1 stuck-0, 2 OR (inverted), 3 random per-vector flips
  int       dp_mode = 0;
  logic [3:0] dp_mask = '0;

  nor_test_sequencer_if #(.WIDTH(1)) ifc ();

  nor_test_sequencer #(
    .WIDTH      (1),
    .SETTLE_CYC (1),
    .ERR_W      (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start_i),
    .abort_i      (abort_i),
    .bus          (ifc),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .pass_o       (pass_o),
    .err_cnt_o    (err_cnt_o),
    .fail_valid_o (fail_valid_o),
    .fail_a_o     (fail_a_o),
    .fail_b_o     (fail_b_o),
    .fail_y_o     (fail_y_o)
  );

  always #5 clk = ~clk;

  always_comb begin
    ifc.y_i = ~(ifc.a_o | ifc.b_o);
    case (dp_mode)
      1:       ifc.y_i = 1'b0;
      2:       ifc.y_i = ifc.a_o | ifc.b_o;
      3:       ifc.y_i = ~(ifc.a_o | ifc.b_o) ^ dp_mask[{ifc.a_o, ifc.b_o}];
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: what a whole run should report, from the NOR truth table and the fault model.
  int m_err;
  bit m_fv, m_fa, m_fb, m_fy, m_pass;

  function automatic bit dp_y(input int mode, input bit a, input bit b, input logic [3:0] mask);
    bit good;
    good = !(a || b);
    case (mode)
      1:       return 1'b0;
      2:       return a || b;
      3:       return good ^ mask[{a, b}];
      default: return good;
    endcase
  endfunction

  task automatic model_run(input int mode, input logic [3:0] mask);
    bit a, b, y;
    m_err = 0; m_fv = 0; m_fa = 0; m_fb = 0; m_fy = 0;
    for (int v = 0; v < NVEC; v++) begin
      a = (v / 2) % 2 == 1;
      b = v % 2 == 1;
      y = dp_y(mode, a, b, mask);
      if (y != !(a || b)) begin
        if (m_err < 3) m_err++;
        if (!m_fv) begin
          m_fv = 1; m_fa = a; m_fb = b; m_fy = y;
        end
      end
    end
    m_pass = !m_fv;
  endtask

  // Pulse start_i so it is sampled on the next edge; afterwards cyc=1 is the first DRIVE cycle.
  task automatic pulse_start();
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic full_run(input string tag, input bit repulse);
    int cyc;
    bit seen;
    model_run(dp_mode, dp_mask);
    pulse_start();
    cyc  = 1;
    seen = 0;
    while (!seen && cyc <= 60) begin
      if (done_o) begin
        seen = 1;
      end else begin
        if ((cyc - 1) % CYC_PER_VEC == 0 && cyc < DONE_CYC) begin
          check({tag, "_a"}, ifc.a_o, ((cyc - 1) / CYC_PER_VEC) / 2);
          check({tag, "_b"}, ifc.b_o, ((cyc - 1) / CYC_PER_VEC) % 2);
        end
        if (repulse && cyc == 5) start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        cyc++;
      end
    end
    if (!seen) check({tag, "_timeout"}, 0, 1);
    check({tag, "_done_lat"}, cyc, DONE_CYC);
    @(posedge clk); #1;
    check({tag, "_done_1cyc"}, done_o, 0);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_pass"}, pass_o, m_pass);
    check({tag, "_err"}, err_cnt_o, m_err);
    check({tag, "_fv"}, fail_valid_o, m_fv);
    check({tag, "_fa"}, fail_a_o, m_fa);
    check({tag, "_fb"}, fail_b_o, m_fb);
    check({tag, "_fy"}, fail_y_o, m_fy);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_a"}, ifc.a_o, 0);
    check({tag, "_b"}, ifc.b_o, 0);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_done"}, done_o, 0);
    check({tag, "_pass"}, pass_o, 0);
    check({tag, "_err"}, err_cnt_o, 0);
    check({tag, "_fv"}, fail_valid_o, 0);
    check({tag, "_fa"}, fail_a_o, 0);
    check({tag, "_fb"}, fail_b_o, 0);
    check({tag, "_fy"}, fail_y_o, 0);
  endtask

  initial begin
    int ndone;
    #2;
    check_all_zero("rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    dp_mode = 0; full_run("good", 1'b0);
    dp_mode = 1; full_run("stuck0", 1'b0);
    dp_mode = 2; full_run("inv_sat", 1'b0);
    dp_mode = 0; full_run("repulse", 1'b1);

    // start and abort together in IDLE: abort wins
    start_i = 1'b1; abort_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0; abort_i = 1'b0;
    check("idle_abort_busy", busy_o, 0);
    @(posedge clk); #1;
    check("idle_abort_busy2", busy_o, 0);

    // abort in DRIVE of vector 2; partial error state is kept
    dp_mode = 1;
    pulse_start();
    for (int c = 1; c < 7; c++) begin
      @(posedge clk); #1;
    end
    check("abort_at_v2_a", ifc.a_o, 1);
    check("abort_at_v2_b", ifc.b_o, 0);
    check("abort_pre_busy", busy_o, 1);
    abort_i = 1'b1;
    @(posedge clk); #1;
    abort_i = 1'b0;
    check("abort_busy", busy_o, 0);
    check("abort_pass", pass_o, 0);
    check("abort_err", err_cnt_o, 1);
    check("abort_fv", fail_valid_o, 1);
    check("abort_fy", fail_y_o, 0);
    ndone = 0;
    for (int c = 0; c < 20; c++) begin
      if (done_o) ndone++;
      @(posedge clk); #1;
    end
    check("abort_no_done", ndone, 0);

    // reset during SETTLE of vector 3, after three saturating mismatches
    dp_mode = 2;
    pulse_start();
    for (int c = 1; c < 11; c++) begin
      @(posedge clk); #1;
    end
    check("pre_rst_err", err_cnt_o, 3);
    check("pre_rst_a", ifc.a_o, 1);
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    dp_mode = 0; full_run("post_rst", 1'b0);

    // randomized fault modes, idle gaps and stray start pulses
    for (int r = 0; r < 8; r++) begin
      dp_mode = int'($urandom_range(0, 3));
      dp_mask = 4'($urandom);
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
        @(posedge clk); #1;
      end
      full_run("rand", 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
